// File: rtl/aes_dec_top.sv
// rtl/aes_dec_top.sv - iterative AES-128 decryptor with on-the-fly key expansion
// Optional round-key reuse for a repeated key: define AES_DEC_KEY_CACHE_EN.
module aes_dec_top (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] ciphertext,
  input  logic [127:0] cipher_key,
  output logic [127:0] plaintext,
  output logic         done,
  output logic         busy
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, FINISH} state_t;

  state_t         state, state_nxt;
  logic [3:0]     rnd;
  logic [127:0]   ct_q, st, round_out;
  logic [127:0]   rk [0:10];
  logic           hit;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by a 4-bit constant built from doublings
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return (m[0] ? a : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] p, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {SBOX[p[23:16]], SBOX[p[15:8]], SBOX[p[7:0]], SBOX[p[31:24]]} ^ {rc, 24'h0};
    w0 = p[127:96] ^ t;
    w1 = p[95:64] ^ w0;
    w2 = p[63:32] ^ w1;
    w3 = p[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // InvShiftRows + InvSubBytes + AddRoundKey, then optional InvMixColumns
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic mix);
    logic [127:0] t;
    logic [7:0]   a0, a1, a2, a3;
    int           src;
    t = '0;
    for (int i = 0; i < 16; i++) begin
      src = 4 * (((i / 4) - (i % 4) + 4) % 4) + (i % 4);
      t[127-8*i -: 8] = INV_SBOX[s[127-8*src -: 8]];
    end
    t = t ^ k;
    if (mix) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[127-32*c -: 8];
        a1 = t[119-32*c -: 8];
        a2 = t[111-32*c -: 8];
        a3 = t[103-32*c -: 8];
        t[127-32*c -: 8] = gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9);
        t[119-32*c -: 8] = gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13);
        t[111-32*c -: 8] = gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11);
        t[103-32*c -: 8] = gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14);
      end
    end
    return t;
  endfunction

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] cache_key;
  logic         cache_vld;
  assign hit = cache_vld && (cipher_key == cache_key);
`else
  assign hit = 1'b0;
`endif

  assign round_out = inv_round(st, rk[rnd], rnd != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = hit ? INIT : KEYEXP;
      KEYEXP: begin
        busy = 1'b1;
        if (rnd == 4'd10) state_nxt = INIT;
      end
      INIT: begin
        busy      = 1'b1;
        state_nxt = ROUND;
      end
      ROUND: begin
        busy = 1'b1;
        if (rnd == 4'd0) state_nxt = FINISH;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ct_q      <= '0;
      st        <= '0;
      plaintext <= '0;
      rnd       <= '0;
      for (int i = 0; i < 11; i++) rk[i] <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_key <= '0;
      cache_vld <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          ct_q  <= ciphertext;
          rk[0] <= cipher_key;
          rnd   <= 4'd1;
`ifdef AES_DEC_KEY_CACHE_EN
          // rk[1..10] are about to be overwritten for a new key
          if (!hit) cache_vld <= 1'b0;
`endif
        end
        KEYEXP: begin
          rk[rnd] <= key_step(rk[rnd - 4'd1], rcon(rnd));
          rnd     <= rnd + 4'd1;
`ifdef AES_DEC_KEY_CACHE_EN
          if (rnd == 4'd10) begin
            cache_key <= rk[0];
            cache_vld <= 1'b1;
          end
`endif
        end
        INIT: begin
          st  <= ct_q ^ rk[10];
          rnd <= 4'd9;
        end
        ROUND: begin
          if (rnd == 4'd0) begin
            plaintext <= round_out;
          end else begin
            st  <= round_out;
            rnd <= rnd - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/aes_dec_top.md
AES_DEC_TOP -- requirements
Module: aes_dec_top

Interface
REQ-001 Parameters: none; key length is fixed at AES-128, 10 rounds.
REQ-002 clk  input  1  sole clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request pulse; sampled only while busy=0.
REQ-005 ciphertext  input  128  block to decrypt; bit 127 is byte 0 MSB (FIPS-197 order).
REQ-006 cipher_key  input  128  AES-128 key, same byte order as ciphertext.
REQ-007 plaintext  output  128  registered decryption result.
REQ-008 done  output  1  one-cycle pulse: plaintext is valid.
REQ-009 busy  output  1  high from the start-accept edge until the edge on which done rises.

Function
REQ-010 The FSM SHALL have the states IDLE, KEYEXP, INIT, ROUND and FINISH.
REQ-011 IDLE: on a rising edge with start=1, latch ciphertext and cipher_key, store rk[0]=cipher_key, set busy=1, enter KEYEXP.
REQ-012 KEYEXP: each cycle computes rk[i] from rk[i-1] (RotWord, SubWord, Rcon 01,02,04,08,10,20,40,80,1b,36) and stores it in an 11-entry round-key file, for i=1..10 over 10 cycles; then enter INIT.
REQ-013 INIT: state = latched ciphertext XOR rk[10] (1 cycle); round counter = 9; enter ROUND.
REQ-014 ROUND: one inverse round per cycle for r=9 down to 1: InvShiftRows, InvSubBytes, XOR rk[r], InvMixColumns.
REQ-015 Final round (r=0): InvShiftRows, InvSubBytes, XOR rk[0], with no InvMixColumns; the result is written to plaintext and the FSM enters FINISH.
REQ-016 FINISH: done=1 and busy=0 for exactly one cycle; return to IDLE.
REQ-017 Latency without a cache hit: done is high in the cycle after edge k+21, where k is the start-accept edge.
REQ-018 plaintext SHALL hold its value until the next FINISH; it never shows intermediate state.
REQ-019 start while busy=1 (including in FINISH) SHALL be ignored and not queued.
REQ-020 Changes on ciphertext or cipher_key after the accept edge SHALL have no effect on the current operation.
REQ-021 start held high continuously SHALL be accepted again in the first IDLE cycle after FINISH, i.e. back-to-back operation at one block per 23 cycles.
REQ-022 The S-box and inverse S-box SHALL be combinational lookup tables; no S-box RAM latency.

Reset
REQ-023 rst_n=0 SHALL immediately force: FSM=IDLE, plaintext=0, done=0, busy=0, round counter=0, round-key file=0.
REQ-024 Reset asserted mid-operation SHALL abort it with no done pulse; the first start after rst_n rises is processed normally.
REQ-025 Reset SHALL invalidate the key cache (see REQ-026).

Configuration
REQ-026 Macro AES_DEC_KEY_CACHE_EN, when defined, adds a cached-key register and a valid flag, set at the end of KEYEXP.
REQ-027 With AES_DEC_KEY_CACHE_EN defined: when a start is accepted with cipher_key equal to the cached key and valid=1, KEYEXP is skipped (IDLE -> INIT), the stored rk[0..10] are reused, and done appears after edge k+11.
REQ-028 With AES_DEC_KEY_CACHE_EN undefined: there is no cache logic, and every operation runs KEYEXP (latency per REQ-017).
REQ-029 Functional results SHALL be identical with and without the macro; only latency differs.

Verification
REQ-030 Key 000102030405060708090a0b0c0d0e0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext 00112233445566778899aabbccddeeff, done high after edge k+21.
REQ-031 Key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32 -> plaintext 3243f6a8885a308d313198a2e0370734.
REQ-032 With AES_DEC_KEY_CACHE_EN defined, repeat REQ-031 immediately with the same key -> same plaintext, done after edge k+11; then use the REQ-030 key -> latency returns to 21.
REQ-033 Pulse start at cycle 5 of an operation with different inputs -> ignored; the result matches the first request; exactly one done.
REQ-034 Assert rst_n=0 during ROUND -> plaintext=0, busy=0, no done; a following start with the REQ-030 vector gives the correct result at full latency.
REQ-035 Hold start=1 over two operations using the REQ-031 vector -> two done pulses 23 cycles apart (cache off), both with plaintext 3243f6a8885a308d313198a2e0370734.
